// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares the register file read ports between ALU and load/store requesters
// Alternating-priority grant, registered operand return with CDB bypass and x0 forced to zero.
module regfile_read_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A_req_valid,
  output logic              A_req_ready,
  input  logic [ADDR_W-1:0] A_addr1,
  input  logic [ADDR_W-1:0] A_addr2,
  output logic              A_rsp_valid,
  output logic [DATA_W-1:0] A_rsp_data1,
  output logic [DATA_W-1:0] A_rsp_data2,
  input  logic              L_req_valid,
  output logic              L_req_ready,
  input  logic [ADDR_W-1:0] L_addr1,
  input  logic [ADDR_W-1:0] L_addr2,
  input  logic              L_use1,
  input  logic              L_use2,
  output logic              L_rsp_valid,
  output logic [DATA_W-1:0] L_rsp_data1,
  output logic [DATA_W-1:0] L_rsp_data2,
  input  logic              cdb_valid,
  input  logic [ADDR_W-1:0] cdb_addr,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic {PRI_A, PRI_L} pri_e;

  pri_e              pri_q;
  logic              grant_a;
  logic              grant_l;
  logic [DATA_W-1:0] op1_d;
  logic [DATA_W-1:0] op2_d;
  logic              a_vld_q;
  logic              l_vld_q;
  logic [DATA_W-1:0] a_data1_q;
  logic [DATA_W-1:0] a_data2_q;
  logic [DATA_W-1:0] l_data1_q;
  logic [DATA_W-1:0] l_data2_q;

  // Unused L operands arrive here as address 0, so the x0 rule also zeroes them.
  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] rdata);
    if (addr == '0) return '0;
    if (cdb_valid && (cdb_addr == addr)) return cdb_data;
    return rdata;
  endfunction

  always_comb begin
    grant_a   = A_req_valid && (!L_req_valid || (pri_q == PRI_A));
    grant_l   = L_req_valid && !grant_a;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    if (grant_a) begin
      rf_raddr1 = A_addr1;
      rf_raddr2 = A_addr2;
    end else if (grant_l) begin
      rf_raddr1 = L_use1 ? L_addr1 : '0;
      rf_raddr2 = L_use2 ? L_addr2 : '0;
    end
    op1_d = operand(rf_raddr1, rf_rdata1);
    op2_d = operand(rf_raddr2, rf_rdata2);
  end

  assign A_req_ready = grant_a;
  assign L_req_ready = grant_l;

  assign rf_we    = cdb_valid && (cdb_addr != '0);
  assign rf_waddr = cdb_addr;
  assign rf_wdata = cdb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q     <= PRI_A;
      a_vld_q   <= 1'b0;
      l_vld_q   <= 1'b0;
      a_data1_q <= '0;
      a_data2_q <= '0;
      l_data1_q <= '0;
      l_data2_q <= '0;
    end else begin
      a_vld_q <= grant_a;
      l_vld_q <= grant_l;
      if (grant_a) begin
        pri_q     <= PRI_L;
        a_data1_q <= op1_d;
        a_data2_q <= op2_d;
      end else if (grant_l) begin
        pri_q     <= PRI_A;
        l_data1_q <= op1_d;
        l_data2_q <= op2_d;
      end
    end
  end

  assign A_rsp_valid = a_vld_q;
  assign A_rsp_data1 = a_data1_q;
  assign A_rsp_data2 = a_data2_q;
  assign L_rsp_valid = l_vld_q;
  assign L_rsp_data1 = l_data1_q;
  assign L_rsp_data2 = l_data2_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
// Directed scenarios then randomized traffic against a behavioural model of grants, register contents and responses.
module tb_regfile_read_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          A_req_valid, A_req_ready, A_rsp_valid;
  logic [AW-1:0] A_addr1, A_addr2;
  logic [DW-1:0] A_rsp_data1, A_rsp_data2;
  logic          L_req_valid, L_req_ready, L_rsp_valid, L_use1, L_use2;
  logic [AW-1:0] L_addr1, L_addr2;
  logic [DW-1:0] L_rsp_data1, L_rsp_data2;
  logic          cdb_valid;
  logic [AW-1:0] cdb_addr;
  logic [DW-1:0] cdb_data;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic          rf_we;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .A_req_valid(A_req_valid), .A_req_ready(A_req_ready),
    .A_addr1(A_addr1), .A_addr2(A_addr2),
    .A_rsp_valid(A_rsp_valid), .A_rsp_data1(A_rsp_data1), .A_rsp_data2(A_rsp_data2),
    .L_req_valid(L_req_valid), .L_req_ready(L_req_ready),
    .L_addr1(L_addr1), .L_addr2(L_addr2), .L_use1(L_use1), .L_use2(L_use2),
    .L_rsp_valid(L_rsp_valid), .L_rsp_data1(L_rsp_data1), .L_rsp_data2(L_rsp_data2),
    .cdb_valid(cdb_valid), .cdb_addr(cdb_addr), .cdb_data(cdb_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Bench-owned register file driven by the DUT write port, plus an independent shadow of architectural state.
  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] shadow [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  int n_chk = 0;
  int n_fail = 0;
  bit prefer_a = 1'b1;
  bit ea_v, el_v;
  logic [DW-1:0] ea1, ea2, el1, el2;
  int a_wait = 0;
  int l_wait = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] expect_op(input logic [AW-1:0] a, input bit use_op);
    if (!use_op || a == 0) return '0;
    if (cdb_valid && cdb_addr == a) return cdb_data;
    return shadow[a];
  endfunction

  task automatic idle();
    rst = 0; A_req_valid = 0; A_addr1 = 0; A_addr2 = 0;
    L_req_valid = 0; L_addr1 = 0; L_addr2 = 0; L_use1 = 1; L_use2 = 1;
    cdb_valid = 0; cdb_addr = 0; cdb_data = 0;
  endtask

  // Inputs are applied at a falling edge; this checks combinational outputs, clocks once, then checks responses.
  task automatic cycle(output bit ga, output bit gl);
    logic [AW-1:0] ra1, ra2, wa;
    logic [DW-1:0] na1, na2, nl1, nl2, wd;
    logic we_s;
    #1;
    ga = A_req_valid && (!L_req_valid || prefer_a);
    gl = L_req_valid && !ga;
    chk("A_req_ready", A_req_ready, ga);
    chk("L_req_ready", L_req_ready, gl);
    chk("both_ready", A_req_ready & L_req_ready, 0);
    chk("ready_wo_valid", (A_req_ready & ~A_req_valid) | (L_req_ready & ~L_req_valid), 0);
    ra1 = ga ? A_addr1 : (gl && L_use1) ? L_addr1 : '0;
    ra2 = ga ? A_addr2 : (gl && L_use2) ? L_addr2 : '0;
    chk("rf_raddr1", rf_raddr1, ra1);
    chk("rf_raddr2", rf_raddr2, ra2);
    chk("rf_we", rf_we, cdb_valid && cdb_addr != 0);
    chk("rf_waddr", rf_waddr, cdb_addr);
    chk("rf_wdata", rf_wdata, cdb_data);
    a_wait = (A_req_valid && !ga) ? a_wait + 1 : 0;
    l_wait = (L_req_valid && !gl) ? l_wait + 1 : 0;
    chk("A_fair", a_wait <= 1, 1);
    chk("L_fair", l_wait <= 1, 1);
    na1 = expect_op(A_addr1, 1'b1);
    na2 = expect_op(A_addr2, 1'b1);
    nl1 = expect_op(L_addr1, L_use1);
    nl2 = expect_op(L_addr2, L_use2);
    we_s = rf_we; wa = rf_waddr; wd = rf_wdata;
    @(posedge clk);
    #1;
    if (we_s) rf_mem[wa] = wd;
    if (cdb_valid && cdb_addr != 0) shadow[cdb_addr] = cdb_data;
    if (rst) begin
      prefer_a = 1; ea_v = 0; el_v = 0; ea1 = 0; ea2 = 0; el1 = 0; el2 = 0;
      a_wait = 0; l_wait = 0;
    end else begin
      ea_v = ga; el_v = gl;
      if (ga) begin prefer_a = 0; ea1 = na1; ea2 = na2; end
      else if (gl) begin prefer_a = 1; el1 = nl1; el2 = nl2; end
    end
    @(negedge clk);
    chk("A_rsp_valid", A_rsp_valid, ea_v);
    chk("A_rsp_data1", A_rsp_data1, ea1);
    chk("A_rsp_data2", A_rsp_data2, ea2);
    chk("L_rsp_valid", L_rsp_valid, el_v);
    chk("L_rsp_data1", L_rsp_data1, el1);
    chk("L_rsp_data2", L_rsp_data2, el2);
  endtask

  initial begin
    bit ga, gl;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      shadow[i] = rf_mem[i];
    end
    rf_mem[3] = 32'h11; shadow[3] = 32'h11;
    rf_mem[4] = 32'h22; shadow[4] = 32'h22;

    idle(); rst = 1;
    cycle(ga, gl); cycle(ga, gl);
    idle();

    A_req_valid = 1; A_addr1 = 3; A_addr2 = 4;
    cycle(ga, gl);
    idle(); cycle(ga, gl);
    chk("dir_A_rsp1", A_rsp_data1, 32'h11);
    chk("dir_A_rsp2", A_rsp_data2, 32'h22);

    rst = 1; cycle(ga, gl); idle();
    for (int i = 0; i < 4; i++) begin
      A_req_valid = 1; A_addr1 = 1; A_addr2 = 2;
      L_req_valid = 1; L_addr1 = 6; L_addr2 = 7;
      cycle(ga, gl);
      chk("alt_grant_A", ga, (i % 2) == 0);
    end
    idle(); cycle(ga, gl);

    L_req_valid = 1; L_addr1 = 5; L_addr2 = 9; L_use2 = 0;
    cdb_valid = 1; cdb_addr = 5; cdb_data = 32'hDEAD;
    cycle(ga, gl);
    idle();
    chk("byp_L_d1", L_rsp_data1, 32'hDEAD);
    chk("byp_L_d2", L_rsp_data2, 0);
    A_req_valid = 1; A_addr1 = 5; A_addr2 = 0;
    cycle(ga, gl); idle();
    chk("rf_x5", A_rsp_data1, 32'hDEAD);

    A_req_valid = 1; A_addr1 = 0; A_addr2 = 3;
    cdb_valid = 1; cdb_addr = 0; cdb_data = 32'hFFFF;
    cycle(ga, gl); idle();
    chk("x0_byp", A_rsp_data1, 0);
    A_req_valid = 1; A_addr1 = 0; A_addr2 = 0;
    cycle(ga, gl); idle();
    chk("x0_read", A_rsp_data1, 0);

    A_req_valid = 1; A_addr1 = 3; A_addr2 = 4;
    cycle(ga, gl); idle();
    rst = 1; cycle(ga, gl); idle();
    chk("rst_drop", A_rsp_valid, 0);
    A_req_valid = 1; L_req_valid = 1; L_addr1 = 2;
    cycle(ga, gl);
    chk("rst_pri_A", ga, 1);
    idle(); cycle(ga, gl);

    for (int n = 0; n < 400; n++) begin
      if (!(A_req_valid && !ga)) begin
        A_req_valid = ($urandom_range(0, 9) < 6);
        A_addr1 = $urandom_range(0, 7); A_addr2 = $urandom_range(0, 7);
      end else if ($urandom_range(0, 9) < 2) A_req_valid = 0;
      if (!(L_req_valid && !gl)) begin
        L_req_valid = ($urandom_range(0, 9) < 6);
        L_addr1 = $urandom_range(0, 7); L_addr2 = $urandom_range(0, 7);
        L_use1 = $urandom_range(0, 1); L_use2 = $urandom_range(0, 1);
      end else if ($urandom_range(0, 9) < 2) L_req_valid = 0;
      cdb_valid = $urandom_range(0, 1);
      cdb_addr = $urandom_range(0, 7);
      cdb_data = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      cycle(ga, gl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
